// File: rtl/aes_host_bridge_if.sv
// Host bus and AES core handshake bundle for aes_host_bridge.
// slave = bridge side; master = host/core side driving it.
interface aes_host_bridge_if #(
  parameter int DATA_BYTES = 16,
  parameter int KEY_BYTES  = 32,
  parameter int ADDR_W     = 7
);
  logic [7:0]              DIN;
  logic [ADDR_W-1:0]       ADDR;
  logic                    WR;
  logic [7:0]              DOUT;
  logic                    OK;
  logic                    BUSY;
  logic [8*KEY_BYTES-1:0]  key_out;
  logic [3:0]              nk;
  logic [3:0]              nr;
  logic                    k_valid;
  logic                    k_done;
  logic [8*DATA_BYTES-1:0] text_out;
  logic                    op;
  logic                    t_valid;
  logic                    t_ready;
  logic [8*DATA_BYTES-1:0] res_in;
  logic                    res_valid;

  modport slave (
    input  DIN, ADDR, WR, k_done, t_ready, res_in, res_valid,
    output DOUT, OK, BUSY, key_out, nk, nr, k_valid, text_out, op, t_valid
  );

  modport master (
    output DIN, ADDR, WR, k_done, t_ready, res_in, res_valid,
    input  DOUT, OK, BUSY, key_out, nk, nr, k_valid, text_out, op, t_valid
  );
endinterface

// File: rtl/aes_host_bridge.sv
// Byte-wide host register file plus sequencer that feeds key and text to the
// AES key-expansion / encrypt cores and captures the result block.
module aes_host_bridge #(
  parameter int DATA_BYTES = 16,
  parameter int KEY_BYTES  = 32,
  parameter int ADDR_W     = 7,
  parameter int TIMEOUT    = 1023
) (
  input logic             CLK,
  input logic             RST,
  aes_host_bridge_if.slave bus
);

  localparam int A_KEY  = 2 * DATA_BYTES;
  localparam int A_CTRL = 2 * DATA_BYTES + KEY_BYTES;
  localparam int A_STAT = A_CTRL + 1;
  localparam int A_CMD  = A_CTRL + 2;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, KLOAD, KWAIT, SEND, RWAIT} state_t;

  state_t                      r_state, w_next;
  logic [DATA_BYTES-1:0][7:0]  r_tx, r_rt, r_text;
  logic [KEY_BYTES-1:0][7:0]   r_key, r_key_out;
  logic [2:0]                  r_ctrl;
  logic                        r_done, r_err, r_drop, r_dirty;
  logic [15:0]                 r_wd;
  logic [7:0]                  r_dout;
  logic [3:0]                  r_nk, r_nr;
  logic                        r_op;

  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_a;
  logic [1:0]        w_size;
  logic              w_tx_hit, w_key_hit, w_ctrl_hit, w_cmd, w_regwr;
  logic              w_start, w_clear, w_go, w_wd_hit, w_tmo;
  logic              w_busy, w_kv, w_tv;
  logic [7:0]        w_rdata;
  int                w_used;

  assign w_addr     = bus.ADDR;
  assign w_a        = 32'(w_addr);
  assign w_size     = r_ctrl[2:1];
  assign w_tx_hit   = w_a < 32'(DATA_BYTES);
  assign w_key_hit  = (w_a >= 32'(A_KEY)) && (w_a < 32'(A_CTRL));
  assign w_ctrl_hit = w_a == 32'(A_CTRL);
  assign w_cmd      = bus.WR && (w_a == 32'(A_CMD));
  assign w_regwr    = bus.WR && (w_tx_hit || w_key_hit || w_ctrl_hit);
  assign w_start    = w_cmd && bus.DIN[0];
  assign w_clear    = w_cmd && bus.DIN[1];
  assign w_go       = w_start && (r_state == IDLE);
  assign w_wd_hit   = r_wd == WD_LAST;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // ---------------- FSM: next state ----------------
  // A completion in the expiry cycle wins over the watchdog.
  always_comb begin
    w_next = r_state;
    w_tmo  = 1'b0;
    case (r_state)
      IDLE:  if (w_go && (w_size != 2'd3)) w_next = r_dirty ? KLOAD : SEND;
      KLOAD: w_next = KWAIT;
      KWAIT: if (bus.k_done) w_next = SEND;
             else if (w_wd_hit) begin w_next = IDLE; w_tmo = 1'b1; end
      SEND:  if (bus.t_ready) w_next = RWAIT;
             else if (w_wd_hit) begin w_next = IDLE; w_tmo = 1'b1; end
      RWAIT: if (bus.res_valid) w_next = IDLE;
             else if (w_wd_hit) begin w_next = IDLE; w_tmo = 1'b1; end
      default: w_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_busy = (r_state != IDLE);
    w_kv   = (r_state == KLOAD);
    w_tv   = (r_state == SEND);
  end

  // Watchdog restarts on every state change and only runs while waiting.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                     r_wd <= '0;
    else if (w_next != r_state || !w_busy)       r_wd <= '0;
    else                                         r_wd <= r_wd + 16'd1;
  end

  // Key bytes actually used by the selected key size; the rest go out as 0.
  always_comb begin
    case (w_size)
      2'd0:    w_used = 16;
      2'd1:    w_used = 24;
      default: w_used = 32;
    endcase
  end

  // ---------------- register file / status / capture ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_tx      <= '0;
      r_rt      <= '0;
      r_key     <= '0;
      r_ctrl    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_drop    <= 1'b0;
      r_dirty   <= 1'b1;
      r_text    <= '0;
      r_key_out <= '0;
      r_nk      <= '0;
      r_nr      <= '0;
      r_op      <= 1'b0;
    end else begin
      if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_drop <= 1'b0;
      end
      if (w_regwr && w_busy) r_drop <= 1'b1;
      if (w_regwr && !w_busy) begin
        for (int b = 0; b < DATA_BYTES; b++)
          if (w_a == 32'(b)) r_tx[b] <= bus.DIN;
        for (int k = 0; k < KEY_BYTES; k++)
          if (w_a == 32'(A_KEY + k)) r_key[k] <= bus.DIN;
        if (w_ctrl_hit) r_ctrl <= bus.DIN[2:0];
        if (w_key_hit || w_ctrl_hit) r_dirty <= 1'b1;
      end
      if (w_go) begin
        if (w_size == 2'd3) begin
          r_err <= 1'b1;
        end else begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_op   <= r_ctrl[0];
          r_nk   <= 4'd4  + {1'b0, w_size, 1'b0};
          r_nr   <= 4'd10 + {1'b0, w_size, 1'b0};
          r_text <= r_tx;
          for (int k = 0; k < KEY_BYTES; k++)
            r_key_out[k] <= (k < w_used) ? r_key[k] : 8'h00;
        end
      end
      if (r_state == KWAIT && bus.k_done) r_dirty <= 1'b0;
      if (w_tmo) begin
        r_err <= 1'b1;
        if (r_state == KWAIT) r_dirty <= 1'b1;
      end
      if (r_state == RWAIT && bus.res_valid) begin
        r_rt   <= bus.res_in;
        r_done <= 1'b1;
      end
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    w_rdata = 8'h00;
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (w_a == 32'(b))              w_rdata = r_tx[b];
      if (w_a == 32'(DATA_BYTES + b)) w_rdata = r_rt[b];
    end
    for (int k = 0; k < KEY_BYTES; k++)
      if (w_a == 32'(A_KEY + k)) w_rdata = r_key[k];
    if (w_ctrl_hit)              w_rdata = {5'd0, r_ctrl};
    if (w_a == 32'(A_STAT))      w_rdata = {4'd0, r_drop, r_err, r_done, w_busy};
  end

  // DOUT only follows read cycles; write cycles leave it alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          r_dout <= 8'h00;
    else if (!bus.WR) r_dout <= w_rdata;
  end

  assign bus.DOUT     = r_dout;
  assign bus.OK       = r_done;
  assign bus.BUSY     = w_busy;
  assign bus.key_out  = r_key_out;
  assign bus.nk       = r_nk;
  assign bus.nr       = r_nr;
  assign bus.k_valid  = w_kv;
  assign bus.text_out = r_text;
  assign bus.op       = r_op;
  assign bus.t_valid  = w_tv;

endmodule

// File: tb/tb_aes_host_bridge.sv
// Directed bench for aes_host_bridge: register map, AES-128/256 flows, key
// reuse, watchdog, busy-write protection and mid-operation reset.
module tb_aes_host_bridge;
  localparam int DB = 16;
  localparam int KB = 32;
  localparam int AW = 7;
  localparam logic [6:0] A_TX = 7'h00, A_RT = 7'h10, A_KEY = 7'h20;
  localparam logic [6:0] A_CTRL = 7'h40, A_STAT = 7'h41, A_CMD = 7'h42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  aes_host_bridge_if #(.DATA_BYTES(DB), .KEY_BYTES(KB), .ADDR_W(AW)) bus ();

  aes_host_bridge #(.DATA_BYTES(DB), .KEY_BYTES(KB), .ADDR_W(AW), .TIMEOUT(1023)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    bus.WR = 1'b1; bus.ADDR = a; bus.DIN = d;
    tick(1);
    bus.WR = 1'b0;
  endtask

  task automatic rd(input logic [6:0] a, output logic [7:0] d);
    bus.WR = 1'b0; bus.ADDR = a;
    tick(1);
    d = bus.DOUT;
  endtask

  // Drives the core side from the cycle after start to completion.
  task automatic run_core(input bit with_key, input logic [127:0] res);
    if (with_key) begin
      tick(1);
      bus.k_done = 1'b1; tick(1); bus.k_done = 1'b0;
    end
    bus.t_ready = 1'b1; tick(1); bus.t_ready = 1'b0;
    bus.res_in = res;
    bus.res_valid = 1'b1; tick(1); bus.res_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1;
    tick(2);
    n_cmp++; if (bus.DOUT !== 8'h00) begin n_bad++; $display("FAIL rst_dout got %h want 00", bus.DOUT); end
    n_cmp++; if ({bus.OK, bus.BUSY, bus.k_valid, bus.t_valid, bus.op} !== 5'b0) begin n_bad++; $display("FAIL rst_flags got %b want 00000", {bus.OK, bus.BUSY, bus.k_valid, bus.t_valid, bus.op}); end
    n_cmp++; if ({bus.nk, bus.nr} !== 8'h00) begin n_bad++; $display("FAIL rst_nknr got %h want 00", {bus.nk, bus.nr}); end
    n_cmp++; if (bus.key_out !== '0 || bus.text_out !== '0) begin n_bad++; $display("FAIL rst_buses key %h text %h want 0", bus.key_out, bus.text_out); end
    rst = 1'b0;
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rst_status got %h want 00", d); end
  endtask

  task automatic test_regmap();
    logic [7:0] d;
    wr(7'h01, 8'h3C);
    rd(7'h01, d);
    n_cmp++; if (d !== 8'h3C) begin n_bad++; $display("FAIL tx_rw got %h want 3c", d); end
    wr(A_RT, 8'h55);
    n_cmp++; if (bus.DOUT !== 8'h3C) begin n_bad++; $display("FAIL dout_hold got %h want 3c", bus.DOUT); end
    rd(7'h43, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL unmapped got %h want 00", d); end
    rd(A_RT, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rt_ro got %h want 00", d); end
    wr(A_CTRL, 8'h05);
    rd(A_CTRL, d);
    n_cmp++; if (d !== 8'h05) begin n_bad++; $display("FAIL ctrl_rw got %h want 05", d); end
    wr(A_CMD, 8'h00);
    rd(A_CMD, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL cmd_read got %h want 00", d); end
  endtask

  task automatic test_aes128();
    logic [127:0] ct, res;
    logic [7:0] d;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 16; i++) res[8*i +: 8] = ct[127-8*i -: 8];
    for (int i = 0; i < 16; i++) wr(A_KEY + 7'(i), 8'(i));
    for (int i = 16; i < 32; i++) wr(A_KEY + 7'(i), 8'hC0 + 8'(i));
    for (int i = 0; i < 16; i++) wr(A_TX + 7'(i), 8'(i * 17));
    wr(A_CTRL, 8'h01);
    wr(A_CMD, 8'h01);
    n_cmp++; if ({bus.BUSY, bus.k_valid, bus.t_valid} !== 3'b110) begin n_bad++; $display("FAIL a128_start busy/kv/tv got %b want 110", {bus.BUSY, bus.k_valid, bus.t_valid}); end
    tick(1);
    n_cmp++; if (bus.k_valid !== 1'b0) begin n_bad++; $display("FAIL a128_kv_one_cycle got %b want 0", bus.k_valid); end
    n_cmp++; if ({bus.nk, bus.nr, bus.op} !== {4'd4, 4'd10, 1'b1}) begin n_bad++; $display("FAIL a128_nknrop got %h/%h/%b want 4/a/1", bus.nk, bus.nr, bus.op); end
    n_cmp++; if (bus.key_out !== {128'h0, 128'h0f0e0d0c0b0a09080706050403020100}) begin n_bad++; $display("FAIL a128_key got %h", bus.key_out); end
    n_cmp++; if (bus.text_out !== 128'hffeeddccbbaa99887766554433221100) begin n_bad++; $display("FAIL a128_text got %h", bus.text_out); end
    tick(3);
    bus.k_done = 1'b1; tick(1); bus.k_done = 1'b0;
    n_cmp++; if (bus.t_valid !== 1'b1) begin n_bad++; $display("FAIL a128_tv_after_kdone got %b want 1", bus.t_valid); end
    bus.t_ready = 1'b1; tick(1); bus.t_ready = 1'b0;
    n_cmp++; if ({bus.BUSY, bus.t_valid} !== 2'b10) begin n_bad++; $display("FAIL a128_rwait busy/tv got %b want 10", {bus.BUSY, bus.t_valid}); end
    tick(9);
    bus.res_in = res; bus.res_valid = 1'b1; tick(1); bus.res_valid = 1'b0;
    n_cmp++; if ({bus.OK, bus.BUSY} !== 2'b10) begin n_bad++; $display("FAIL a128_done ok/busy got %b want 10", {bus.OK, bus.BUSY}); end
    for (int i = 0; i < 16; i++) begin
      rd(A_RT + 7'(i), d);
      n_cmp++; if (d !== ct[127-8*i -: 8]) begin n_bad++; $display("FAIL a128_rt[%0d] got %h want %h", i, d, ct[127-8*i -: 8]); end
    end
  endtask

  task automatic test_key_reuse();
    wr(A_CMD, 8'h01);
    n_cmp++; if ({bus.k_valid, bus.t_valid} !== 2'b01) begin n_bad++; $display("FAIL reuse_skip kv/tv got %b want 01", {bus.k_valid, bus.t_valid}); end
    run_core(1'b0, 128'h0);
    wr(A_KEY, 8'h00);
    wr(A_CMD, 8'h01);
    n_cmp++; if ({bus.k_valid, bus.t_valid} !== 2'b10) begin n_bad++; $display("FAIL reuse_reload kv/tv got %b want 10", {bus.k_valid, bus.t_valid}); end
    run_core(1'b1, 128'h0);
  endtask

  task automatic test_aes256();
    logic [7:0] d;
    for (int i = 0; i < 32; i++) wr(A_KEY + 7'(i), 8'hA0 + 8'(i));
    wr(A_CTRL, 8'h05);
    wr(A_CMD, 8'h01);
    n_cmp++; if ({bus.nk, bus.nr} !== {4'd8, 4'd14}) begin n_bad++; $display("FAIL a256_nknr got %h/%h want 8/e", bus.nk, bus.nr); end
    n_cmp++; if (bus.key_out !== 256'hbfbebdbcbbbab9b8b7b6b5b4b3b2b1b0afaeadacabaaa9a8a7a6a5a4a3a2a1a0) begin n_bad++; $display("FAIL a256_key got %h", bus.key_out); end
    run_core(1'b1, 128'h0);
    wr(A_CMD, 8'h02);
    wr(A_CTRL, 8'h07);
    wr(A_CMD, 8'h01);
    n_cmp++; if ({bus.BUSY, bus.k_valid, bus.t_valid} !== 3'b000) begin n_bad++; $display("FAIL illegal_idle busy/kv/tv got %b want 000", {bus.BUSY, bus.k_valid, bus.t_valid}); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL illegal_err status got %h want 04", d); end
    wr(A_CMD, 8'h02);
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    wr(A_CTRL, 8'h01);
    wr(A_CMD, 8'h01);
    tick(1);
    bus.k_done = 1'b1; tick(1); bus.k_done = 1'b0;
    tick(1022);
    n_cmp++; if ({bus.BUSY, bus.t_valid} !== 2'b11) begin n_bad++; $display("FAIL to_last_cycle busy/tv got %b want 11", {bus.BUSY, bus.t_valid}); end
    tick(1);
    n_cmp++; if ({bus.BUSY, bus.t_valid} !== 2'b00) begin n_bad++; $display("FAIL to_expired busy/tv got %b want 00", {bus.BUSY, bus.t_valid}); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h04) begin n_bad++; $display("FAIL to_err status got %h want 04", d); end
    wr(A_CMD, 8'h02);
    wr(A_CMD, 8'h01);
    tick(1022);
    bus.t_ready = 1'b1; tick(1); bus.t_ready = 1'b0;
    n_cmp++; if ({bus.BUSY, bus.t_valid} !== 2'b10) begin n_bad++; $display("FAIL to_race_accept busy/tv got %b want 10", {bus.BUSY, bus.t_valid}); end
    bus.res_valid = 1'b1; tick(1); bus.res_valid = 1'b0;
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h02) begin n_bad++; $display("FAIL to_race_status got %h want 02", d); end
  endtask

  task automatic test_busy_protect();
    logic [7:0] d;
    wr(A_CMD, 8'h01);
    bus.t_ready = 1'b1; tick(1); bus.t_ready = 1'b0;
    wr(A_CMD, 8'h01);
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h01) begin n_bad++; $display("FAIL busy_start_ignored status got %h want 01", d); end
    wr(A_TX, 8'hAA);
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h09) begin n_bad++; $display("FAIL busy_wrdrop status got %h want 09", d); end
    bus.res_in = 128'h1; bus.res_valid = 1'b1; tick(1); bus.res_valid = 1'b0;
    rd(A_TX, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL busy_tx0 got %h want 00", d); end
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h0A) begin n_bad++; $display("FAIL busy_status_after got %h want 0a", d); end
    wr(A_CMD, 8'h02);
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL clear_status got %h want 00", d); end
  endtask

  task automatic test_reset_midop();
    logic [7:0] d;
    wr(A_KEY, 8'h5A);
    wr(A_CMD, 8'h01);
    tick(1);
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.OK, bus.BUSY, bus.k_valid, bus.t_valid, bus.op, bus.nk, bus.nr} !== 13'b0) begin n_bad++; $display("FAIL midrst_flags got %b want 0", {bus.OK, bus.BUSY, bus.k_valid, bus.t_valid, bus.op, bus.nk, bus.nr}); end
    n_cmp++; if (bus.key_out !== '0 || bus.text_out !== '0 || bus.DOUT !== 8'h00) begin n_bad++; $display("FAIL midrst_buses key %h text %h dout %h want 0", bus.key_out, bus.text_out, bus.DOUT); end
    tick(1);
    rst = 1'b0;
    bus.res_valid = 1'b1; tick(1); bus.res_valid = 1'b0;
    rd(A_STAT, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL midrst_late_res status got %h want 00", d); end
    wr(A_CMD, 8'h01);
    n_cmp++; if (bus.k_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_reload kv got %b want 1", bus.k_valid); end
    run_core(1'b1, 128'h0);
  endtask

  initial begin
    bus.WR = 1'b0; bus.ADDR = '0; bus.DIN = '0;
    bus.k_done = 1'b0; bus.t_ready = 1'b0;
    bus.res_in = '0; bus.res_valid = 1'b0;
    test_reset();
    test_regmap();
    test_aes128();
    test_key_reuse();
    test_aes256();
    test_timeout();
    test_busy_protect();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
